// File: rtl/csr_stream_loader_if.sv
// Bus bundle between the CSR stream loader, its matrix/vector memories and
// the three channel-accumulator input FIFOs.
interface csr_stream_loader_if #(
  parameter int DATA_W = 8,
  parameter int ID_W   = 8,
  parameter int NZ_AW  = 8
);
  logic              start;
  logic [ID_W-1:0]   num_rows;
  logic              busy;
  logic              done;
  logic [ID_W-1:0]   row_ptr_addr;
  logic [NZ_AW-1:0]  row_ptr_data;
  logic [NZ_AW-1:0]  nz_addr;
  logic [ID_W-1:0]   col_idx_data;
  logic [DATA_W-1:0] mat_val_data;
  logic [ID_W-1:0]   vec_addr;
  logic [DATA_W-1:0] vec_data;
  logic [DATA_W-1:0] matrix_val_din;
  logic              matrix_val_wr_en;
  logic              matrix_val_full;
  logic [DATA_W-1:0] vec_val_din;
  logic              vec_val_wr_en;
  logic              vec_val_full;
  logic [ID_W-1:0]   row_id_din;
  logic              row_id_wr_en;
  logic              row_id_full;

  modport master (
    input  start, num_rows, row_ptr_data, col_idx_data, mat_val_data, vec_data,
           matrix_val_full, vec_val_full, row_id_full,
    output busy, done, row_ptr_addr, nz_addr, vec_addr,
           matrix_val_din, matrix_val_wr_en, vec_val_din, vec_val_wr_en,
           row_id_din, row_id_wr_en
  );

  modport slave (
    output start, num_rows, row_ptr_data, col_idx_data, mat_val_data, vec_data,
           matrix_val_full, vec_val_full, row_id_full,
    input  busy, done, row_ptr_addr, nz_addr, vec_addr,
           matrix_val_din, matrix_val_wr_en, vec_val_din, vec_val_wr_en,
           row_id_din, row_id_wr_en
  );
endinterface

// File: rtl/csr_stream_loader.sv
// CSR sparse-matrix walker: for every nonzero pushes one (value, vector entry,
// row id) triple into the three channel FIFOs, 4 cycles per nonzero.
module csr_stream_loader #(
  parameter int DATA_W = 8,
  parameter int ID_W   = 8,
  parameter int NZ_AW  = 8
) (
  input logic           clk,
  input logic           rst,
  csr_stream_loader_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PTR_A    = 4'd1,
    S_PTR_B    = 4'd2,
    S_PTR_C    = 4'd3,
    S_NZ_RD    = 4'd4,
    S_NZ_CAP   = 4'd5,
    S_VEC_CAP  = 4'd6,
    S_PUSH     = 4'd7,
    S_NEXT_ROW = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  localparam logic [ID_W-1:0]  ID_ZERO = ID_W'(0);
  localparam logic [ID_W-1:0]  ID_ONE  = ID_W'(1);
  localparam logic [NZ_AW-1:0] NZ_ZERO = NZ_AW'(0);
  localparam logic [NZ_AW-1:0] NZ_ONE  = NZ_AW'(1);

  state_t            state_r;
  logic [ID_W-1:0]   r_r;
  logic [ID_W-1:0]   nrows_r;
  logic [NZ_AW-1:0]  nz_idx_r;
  logic [NZ_AW-1:0]  nz_end_r;
  logic [ID_W-1:0]   row_ptr_addr_r;
  logic [NZ_AW-1:0]  nz_addr_r;
  logic [ID_W-1:0]   vec_addr_r;
  logic [DATA_W-1:0] mat_din_r;
  logic [DATA_W-1:0] vec_din_r;
  logic [ID_W-1:0]   row_din_r;
  logic              busy_r;
  logic              done_r;

  logic              any_full_s;
  logic              push_s;
  logic [ID_W-1:0]   r_inc_s;
  logic [NZ_AW-1:0]  nz_inc_s;

  // Push decode and wrap-around increments; rst masks the strobe in its own cycle.
  always_comb begin
    any_full_s = bus.matrix_val_full | bus.vec_val_full | bus.row_id_full;
    push_s     = 1'b0;
    if ((state_r == S_PUSH) && !any_full_s && !rst) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    r_inc_s  = r_r + ID_ONE;
    nz_inc_s = nz_idx_r + NZ_ONE;
  end

  // Pass sequencer with registered addresses, FIFO data and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      r_r            <= ID_ZERO;
      nrows_r        <= ID_ZERO;
      nz_idx_r       <= NZ_ZERO;
      nz_end_r       <= NZ_ZERO;
      row_ptr_addr_r <= ID_ZERO;
      nz_addr_r      <= NZ_ZERO;
      vec_addr_r     <= ID_ZERO;
      mat_din_r      <= {DATA_W{1'b0}};
      vec_din_r      <= {DATA_W{1'b0}};
      row_din_r      <= ID_ZERO;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            nrows_r        <= bus.num_rows;
            r_r            <= ID_ZERO;
            row_ptr_addr_r <= ID_ZERO;
            busy_r         <= 1'b1;
            if (bus.num_rows == ID_ZERO) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_PTR_A;
            end
          end
        end
        S_PTR_A: begin
          row_ptr_addr_r <= r_inc_s;
          state_r        <= S_PTR_B;
        end
        S_PTR_B: begin
          nz_idx_r <= bus.row_ptr_data;
          state_r  <= S_PTR_C;
        end
        S_PTR_C: begin
          nz_end_r  <= bus.row_ptr_data;
          nz_addr_r <= nz_idx_r;
          if (nz_idx_r == bus.row_ptr_data) begin
            state_r <= S_NEXT_ROW;
          end else begin
            state_r <= S_NZ_RD;
          end
        end
        S_NZ_RD: begin
          state_r <= S_NZ_CAP;
        end
        S_NZ_CAP: begin
          mat_din_r  <= bus.mat_val_data;
          vec_addr_r <= bus.col_idx_data;
          state_r    <= S_VEC_CAP;
        end
        S_VEC_CAP: begin
          vec_din_r <= bus.vec_data;
          row_din_r <= r_r;
          state_r   <= S_PUSH;
        end
        S_PUSH: begin
          if (!any_full_s) begin
            nz_idx_r  <= nz_inc_s;
            nz_addr_r <= nz_inc_s;
            if (nz_inc_s == nz_end_r) begin
              state_r <= S_NEXT_ROW;
            end else begin
              state_r <= S_NZ_RD;
            end
          end
        end
        S_NEXT_ROW: begin
          r_r            <= r_inc_s;
          row_ptr_addr_r <= r_inc_s;
          if (r_inc_s == nrows_r) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= S_PTR_A;
          end
        end
        S_DONE: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // The vector read must be issued while col_idx_data is on the bus to keep 4 cycles per nonzero.
  assign bus.vec_addr         = (state_r == S_NZ_CAP) ? bus.col_idx_data : vec_addr_r;
  assign bus.row_ptr_addr     = row_ptr_addr_r;
  assign bus.nz_addr          = nz_addr_r;
  assign bus.matrix_val_din   = mat_din_r;
  assign bus.vec_val_din      = vec_din_r;
  assign bus.row_id_din       = row_din_r;
  assign bus.matrix_val_wr_en = push_s;
  assign bus.vec_val_wr_en    = push_s;
  assign bus.row_id_wr_en     = push_s;
  assign bus.busy             = busy_r;
  assign bus.done             = done_r;

endmodule

// File: tb/tb_csr_stream_loader.sv
// Randomized bench for csr_stream_loader: memory models, FIFO-full stimulus and
// a scoreboard of triples derived directly from the CSR arrays.
module tb_csr_stream_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_stream_loader_if #(.DATA_W(8), .ID_W(8), .NZ_AW(8)) bus ();

  csr_stream_loader #(.DATA_W(8), .ID_W(8), .NZ_AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [7:0] rp_mem  [256];
  logic [7:0] ci_mem  [256];
  logic [7:0] mv_mem  [256];
  logic [7:0] vec_mem [256];

  always @(posedge clk) begin
    bus.row_ptr_data <= rp_mem[bus.row_ptr_addr];
    bus.col_idx_data <= ci_mem[bus.nz_addr];
    bus.mat_val_data <= mv_mem[bus.nz_addr];
    bus.vec_data     <= vec_mem[bus.vec_addr];
  end

  logic       rand_full_en = 1'b0;
  logic [2:0] rnd_full     = 3'b000;
  logic [2:0] force_full   = 3'b000;
  always @(posedge clk) begin
    rnd_full <= {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
  end
  assign bus.matrix_val_full = rand_full_en ? rnd_full[0] : force_full[0];
  assign bus.vec_val_full    = rand_full_en ? rnd_full[1] : force_full[1];
  assign bus.row_id_full     = rand_full_en ? rnd_full[2] : force_full[2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  logic [23:0] exp_q[$];
  int          push_cyc[$];
  int          cyc      = 0;
  int          acc_cyc  = 0;
  int          push_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          no_push  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must be a full aligned triple matching the next expected one.
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.matrix_val_wr_en || bus.vec_val_wr_en || bus.row_id_wr_en) begin
      check_eq("wr_en_aligned", {29'd0, bus.matrix_val_wr_en, bus.vec_val_wr_en, bus.row_id_wr_en}, 32'd7);
      if (no_push || exp_q.size() == 0) begin
        check_eq("unexpected_push", {29'd0, bus.matrix_val_wr_en, bus.vec_val_wr_en, bus.row_id_wr_en}, 32'd0);
      end else begin
        check_eq("triple", {8'd0, bus.matrix_val_din, bus.vec_val_din, bus.row_id_din}, {8'd0, exp_q.pop_front()});
      end
      push_cyc.push_back(cyc);
      push_cnt++;
    end
  end

  function automatic void build_expected(input int nr);
    for (int r = 0; r < nr; r++) begin
      for (int k = int'(rp_mem[r]); k < int'(rp_mem[r + 1]); k++) begin
        exp_q.push_back({mv_mem[k], vec_mem[ci_mem[k]], 8'(r)});
      end
    end
  endfunction

  task automatic load_example();
    logic [7:0] rp [4] = '{8'd0, 8'd2, 8'd2, 8'd5};
    logic [7:0] ci [5] = '{8'd0, 8'd3, 8'd1, 8'd2, 8'd3};
    logic [7:0] vv [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
    for (int i = 0; i < 4; i++) rp_mem[i] = rp[i];
    for (int i = 0; i < 5; i++) begin
      ci_mem[i] = ci[i];
      mv_mem[i] = 8'(i + 1);
    end
    for (int i = 0; i < 4; i++) vec_mem[i] = vv[i];
  endtask

  task automatic start_pass(input logic [7:0] nr, input bit hold);
    push_cyc.delete();
    push_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    bus.num_rows = nr;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic finish_pass(input bit hold, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
      if (hold) bus.num_rows = 8'($urandom);
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("done_once", 32'(done_cnt), 32'd1);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    check_eq("busy_after", {31'd0, bus.busy}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int nr;
    int k;
    bit hold;
    for (int i = 0; i < 256; i++) begin
      rp_mem[i] = 8'd0; ci_mem[i] = 8'd0; mv_mem[i] = 8'd0; vec_mem[i] = 8'd0;
    end
    bus.start    = 1'b0;
    bus.num_rows = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_wr_en", {29'd0, bus.matrix_val_wr_en, bus.vec_val_wr_en, bus.row_id_wr_en}, 32'd0);
    check_eq("rst_addr", {8'd0, bus.row_ptr_addr, bus.nz_addr, bus.vec_addr}, 32'd0);
    check_eq("rst_din", {8'd0, bus.matrix_val_din, bus.vec_val_din, bus.row_id_din}, 32'd0);
    rst = 1'b0;

    // Example matrix, no backpressure: first push 6 cycles after PTR_A, 4-cycle spacing inside rows.
    load_example();
    build_expected(3);
    start_pass(8'd3, 1'b0);
    check_eq("busy_run", {31'd0, bus.busy}, 32'd1);
    finish_pass(1'b0, 200);
    check_eq("ex_push_cnt", 32'(push_cnt), 32'd5);
    if (push_cnt == 5) begin
      check_eq("ex_first_lat", 32'(push_cyc[0] - acc_cyc), 32'd6);
      check_eq("ex_gap_row0", 32'(push_cyc[1] - push_cyc[0]), 32'd4);
      check_eq("ex_gap_row2a", 32'(push_cyc[3] - push_cyc[2]), 32'd4);
      check_eq("ex_gap_row2b", 32'(push_cyc[4] - push_cyc[3]), 32'd4);
    end

    // vec_val_full high for the first 6 PUSH cycles.
    build_expected(3);
    start_pass(8'd3, 1'b0);
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      if (j == 5) force_full = 3'b010;
      if (j == 12) force_full = 3'b000;
      if (j >= 6 && j <= 11) begin
        @(negedge clk);
        check_eq("stall_no_wr", {31'd0, bus.vec_val_wr_en}, 32'd0);
        check_eq("stall_din", {8'd0, bus.matrix_val_din, bus.vec_val_din, bus.row_id_din}, {8'd0, 8'd1, 8'd10, 8'd0});
      end
    end
    finish_pass(1'b0, 200);
    check_eq("stall_push_cnt", 32'(push_cnt), 32'd5);
    if (push_cnt > 0) check_eq("stall_release", 32'(push_cyc[0] - acc_cyc), 32'd12);

    // Zero rows: immediate done, no pushes.
    start_pass(8'd0, 1'b0);
    finish_pass(1'b0, 20);
    check_eq("zero_done_lat", 32'((done_cyc - (acc_cyc - 1)) <= 2), 32'd1);
    check_eq("zero_push_cnt", 32'(push_cnt), 32'd0);

    // Reset after the second push, then a clean full pass.
    build_expected(3);
    start_pass(8'd3, 1'b0);
    k = 0;
    while (push_cnt < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("rst_reach_push2", 32'(push_cnt), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    no_push = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("midrst_done", 32'(done_cnt), 32'd0);
    no_push = 1'b0;
    exp_q.delete();
    build_expected(3);
    start_pass(8'd3, 1'b0);
    finish_pass(1'b0, 200);
    check_eq("rerun_push_cnt", 32'(push_cnt), 32'd5);

    // start held and num_rows scrambled through the pass.
    build_expected(3);
    start_pass(8'd3, 1'b1);
    finish_pass(1'b1, 200);
    check_eq("hold_push_cnt", 32'(push_cnt), 32'd5);

    // Random matrices with random backpressure and random start holding.
    for (int t = 0; t < 30; t++) begin
      nr = $urandom_range(0, 6);
      rp_mem[0] = 8'($urandom_range(0, 3));
      for (int r = 0; r < nr; r++) rp_mem[r + 1] = rp_mem[r] + 8'($urandom_range(0, 3));
      for (int i = 0; i < 32; i++) begin
        ci_mem[i] = 8'($urandom_range(0, 15));
        mv_mem[i] = 8'($urandom);
      end
      for (int i = 0; i < 16; i++) vec_mem[i] = 8'($urandom);
      rand_full_en = ($urandom_range(0, 1) == 1);
      hold = ($urandom_range(0, 2) == 0);
      build_expected(nr);
      k = exp_q.size();
      start_pass(8'(nr), hold);
      finish_pass(hold, 2000);
      check_eq("rnd_push_cnt", 32'(push_cnt), 32'(k));
      rand_full_en = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
